password_clock_monitor: RTL
===========================

// Module: password_clock_monitor
// PURPOSE
//  Checks a divided clock (nominally CLK_FREQ/(2*FREQ) cycles per half-period) from inside the fast clk domain.
//  Synchronises clk_in and emits one-cycle rise/fall enable pulses.
//  Measures each half-period, reports lock when the rate matches, and flags a fault if clk_in stops.
//  Used by the password logic to qualify its slow timebase and to derive clk-domain enables.
// PARAMETERS
//  CLK_FREQ    50_000_000  frequency of clk in Hz
//  FREQ        12_500_000  expected frequency of clk_in in Hz; localparam HALF = CLK_FREQ/(2*FREQ)
//  TOL         0           allowed |measured - HALF| deviation, in clk cycles
//  LOCK_COUNT  4           consecutive in-tolerance measurements required to assert locked
//  SYNC_STAGES 2           synchroniser flops on clk_in (min 2); localparam TIMEOUT = 4*HALF
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  clk_in       in   1   divided clock under test (asynchronous to clk)
//  tick         out  1   one-cycle pulse per clk_in rising edge
//  fall_tick    out  1   one-cycle pulse per clk_in falling edge
//  half_period  out  32  last measured half-period in clk cycles
//  meas_valid   out  1   one-cycle pulse: half_period was updated this cycle
//  locked       out  1   rate is stable and within tolerance
//  err          out  1   one-cycle pulse: measurement was out of tolerance
//  fault        out  1   no clk_in edge for TIMEOUT cycles
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk): sync chain, prev sample, cnt, good count and every output go to 0; state = IDLE.
//    Reset applies in any state, including mid-measurement.
//  - Edge detect: clk_in feeds SYNC_STAGES flops. prev holds the last synced value. edge = sync_out != prev.
//    tick/fall_tick are registered. They assert SYNC_STAGES+1 posedges after the first posedge that samples the new clk_in level.
//  - cnt (32b, saturating at 32'hFFFF_FFFF): on an edge cycle, measured = cnt+1 and cnt <= 0; otherwise cnt <= cnt+1.
//    A toggle every N clk cycles therefore measures N.
//  - In tolerance: HALF-TOL <= measured <= HALF+TOL, compared in 33-bit arithmetic with no underflow.
//  - States:
//    IDLE:    first edge -> MEASURE. This measurement is discarded: no meas_valid, half_period unchanged.
//    MEASURE: each edge: half_period <= measured, meas_valid=1.
//             In tolerance: good++. When good reaches LOCK_COUNT -> LOCKED and locked=1 on the same registered update.
//             Out of tolerance: good <= 0, err=1.
//    LOCKED:  each edge: half_period/meas_valid as in MEASURE.
//             Out of tolerance: err=1, locked <= 0, good <= 0 -> MEASURE.
//    FAULT:   fault=1, locked=0. First edge -> MEASURE with the measurement discarded. fault clears on that cycle.
//  - Timeout: in IDLE, MEASURE or LOCKED, when cnt reaches TIMEOUT-1 without an edge: -> FAULT, fault <= 1, locked <= 0, good <= 0.
//    If an edge and the timeout occur in the same cycle, the edge wins.
//  - meas_valid, err, tick and fall_tick are never held longer than one cycle.
//    err implies meas_valid in the same cycle.
//  - half_period holds its value between updates, and in FAULT.
// TESTING (bench overrides FREQ=5_000_000 -> HALF=5, TOL=1, LOCK_COUNT=4, TIMEOUT=20)
//  1 Reset, then clk_in toggles every 5 clk.
//    -> First edge gives no meas_valid. Each later edge gives meas_valid with half_period=5.
//    -> locked rises with the 4th meas_valid. err and fault stay 0.
//  2 After lock, half-periods alternate 4,6 -> locked stays 1, no err.
//    Then one 7-cycle half-period -> err=1, meas_valid=1, half_period=7, locked=0.
//    Relock needs 4 more good measurements.
//  3 After lock, hold clk_in low -> fault=1 and locked=0 exactly 20 cycles after the last edge.
//    Resume toggling -> fault clears on the first edge with no meas_valid.
//    locked returns after 4 more measurements.
//  4 Single rising then falling transition of clk_in -> tick, then fall_tick.
//    Each is exactly 1 cycle wide and arrives SYNC_STAGES+1 cycles after sampling.
//    tick and fall_tick are never asserted together.
//  5 Assert rst for 1 cycle while LOCKED and mid-count -> next cycle all outputs 0 and state IDLE.
//    Resumed toggling follows scenario 1 timing.
//  6 clk_in=1 at reset release, then normal toggling.
//    -> The spurious first edge is discarded with no meas_valid and no err.
//    -> No clk_in activity for 20 cycles after reset drives fault=1 from IDLE.

Source files
------------

// File: rtl/password_clock_monitor.sv
// Rate monitor for a slow divided clock sampled in the fast clk domain.
// Produces edge enables, half-period measurements, lock and stuck-clock fault.
//   state      | meaning
//   ST_IDLE    | after reset, waiting for a first edge to start timing
//   ST_MEASURE | timing half-periods, counting consecutive good ones
//   ST_LOCKED  | LOCK_COUNT good measurements seen, rate qualified
//   ST_FAULT   | no edge for TIMEOUT cycles, waiting for activity
module password_clock_monitor #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned FREQ        = 12_500_000,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_in,
  output logic        tick,
  output logic        fall_tick,
  output logic [31:0] half_period,
  output logic        meas_valid,
  output logic        locked,
  output logic        err,
  output logic        fault
);

  localparam int unsigned HALF    = CLK_FREQ / (2 * FREQ);
  localparam int unsigned TIMEOUT = 4 * HALF;
  localparam int unsigned NS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned GW      = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [32:0] HALF33  = 33'(HALF);
  localparam logic [32:0] TOL33   = 33'(TOL);
  localparam logic [32:0] HI33    = 33'(HALF) + 33'(TOL);
  localparam logic [31:0] TO_CNT  = 32'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  logic [NS-1:0] sync_q;
  logic          prev_q;
  logic [31:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [31:0]   half_q, half_d;
  logic          tick_q, tick_d;
  logic          fall_q, fall_d;
  logic          mv_q, mv_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          fault_q, fault_d;

  logic          sync_out;
  logic          edge_w;
  logic [31:0]   measured;
  logic [32:0]   meas33;
  logic          in_tol;

  assign sync_out = sync_q[NS-1];
  assign edge_w   = sync_out ^ prev_q;
  // Saturating increment doubles as the measured length of the current half-period.
  assign measured = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign meas33   = {1'b0, measured};
  assign in_tol   = ((meas33 + TOL33) >= HALF33) && (meas33 <= HI33);

  always_comb begin
    cnt_d    = edge_w ? 32'd0 : measured;
    state_d  = state_q;
    good_d   = good_q;
    half_d   = half_q;
    locked_d = locked_q;
    fault_d  = fault_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    tick_d   = edge_w & sync_out;
    fall_d   = edge_w & ~sync_out;

    if (edge_w) begin
      case (state_q)
        ST_IDLE, ST_FAULT: begin
          // First edge only restarts timing; its interval is meaningless.
          state_d = ST_MEASURE;
          fault_d = 1'b0;
          good_d  = '0;
        end
        default: begin
          mv_d   = 1'b1;
          half_d = measured;
          if (!in_tol) begin
            err_d    = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
            state_d  = ST_MEASURE;
          end else if (state_q == ST_MEASURE) begin
            if (good_q == GW'(LOCK_COUNT - 1)) begin
              good_d   = GW'(LOCK_COUNT);
              locked_d = 1'b1;
              state_d  = ST_LOCKED;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
      endcase
    end else if (state_q != ST_FAULT && cnt_q == TO_CNT) begin
      state_d  = ST_FAULT;
      fault_d  = 1'b1;
      locked_d = 1'b0;
      good_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= 32'd0;
      state_q  <= ST_IDLE;
      good_q   <= '0;
      half_q   <= 32'd0;
      tick_q   <= 1'b0;
      fall_q   <= 1'b0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[NS-2:0], clk_in};
      prev_q   <= sync_out;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      good_q   <= good_d;
      half_q   <= half_d;
      tick_q   <= tick_d;
      fall_q   <= fall_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      fault_q  <= fault_d;
    end
  end

  assign tick        = tick_q;
  assign fall_tick   = fall_q;
  assign half_period = half_q;
  assign meas_valid  = mv_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign fault       = fault_q;

endmodule
